// File: rtl/posit_add_collector.sv
`default_nettype none
// ============================================================================
//  Module   : posit_add_collector
//  Purpose  : Stream wrapper for the fixed-latency pipelined posit adder.
//             Each upstream operation is accepted only when the result FIFO
//             has a slot for it. A valid shift register follows each accepted
//             op through the adder pipeline. The adder result is written into
//             a registered FIFO, which is drained through a valid/ready port.
//  Options  : POSIT_COLLECT_NAR_FLAG_EN - store a NaR flag per entry, and
//             expose out_nar and the sticky nar_seen.
//  Revision : 1.0 - initial release
// ============================================================================
module posit_add_collector #(
    parameter int WIDTH   = 7,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 5,
    parameter int W_CNT   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [W_CNT-1:0] count,
    output logic [W_CNT-1:0] inflight,
`ifdef POSIT_COLLECT_NAR_FLAG_EN
    output logic             out_nar,
    output logic             nar_seen,
`endif
    output logic             err
);

    localparam int               W_PTR     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [W_PTR-1:0] LAST_PTR  = W_PTR'(DEPTH - 1);
    localparam logic [W_CNT-1:0] DEPTH_CNT = W_CNT'(DEPTH);
    localparam logic [W_CNT:0]   DEPTH_EXT = (W_CNT + 1)'(DEPTH);
`ifdef POSIT_COLLECT_NAR_FLAG_EN
    localparam int               ENTRY_W   = WIDTH + 1;
    localparam logic [WIDTH-1:0] NAR_CODE  = {1'b1, {(WIDTH - 1){1'b0}}};
`else
    localparam int               ENTRY_W   = WIDTH;
`endif

    logic [LATENCY-1:0] vsr;
    logic [LATENCY-1:0] vsr_next;
    logic [W_CNT-1:0]   inflight_next;
    logic [W_PTR-1:0]   wr_ptr;
    logic [W_PTR-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] push_entry;
    logic [W_CNT:0]     credit_sum;
    logic               acc;
    logic               push;
    logic               pop;
    logic               full;
    logic               write;
    logic               overflow;
`ifdef POSIT_COLLECT_NAR_FLAG_EN
    logic               q_is_nar;
`endif

    // Advance a FIFO pointer. The pointer wraps at DEPTH, which does not
    // have to be a power of two.
    function automatic logic [W_PTR-1:0] ptr_inc(input logic [W_PTR-1:0] p);
        return (p == LAST_PTR) ? '0 : p + W_PTR'(1);
    endfunction

    // Credit check. It uses only registered counters, so out_ready has no
    // combinational path to in_ready. Every accepted op therefore already
    // owns a FIFO slot.
    always_comb begin
        credit_sum = {1'b0, count} + {1'b0, inflight};
        in_ready   = rst & (credit_sum < DEPTH_EXT);
        acc        = in_valid & in_ready;
    end

    // Next state of the valid shift register. inflight is registered from
    // the popcount of that next state, so the two always stay in step.
    always_comb begin
        vsr_next      = '0;
        inflight_next = '0;
        vsr_next[0]   = acc;
        for (int i = 1; i < LATENCY; i++) begin
            vsr_next[i] = vsr[i-1];
        end
        for (int i = 0; i < LATENCY; i++) begin
            inflight_next = inflight_next + W_CNT'(vsr_next[i]);
        end
    end

    // FIFO control. A push into a full FIFO is legal only when a pop happens
    // in the same cycle; otherwise the result is dropped and flagged.
    always_comb begin
        push      = vsr[LATENCY-1];
        out_valid = rst & (count != '0);
        pop       = out_valid & out_ready;
        full      = (count == DEPTH_CNT);
        write     = push & (~full | pop);
        overflow  = push & full & ~pop;
`ifdef POSIT_COLLECT_NAR_FLAG_EN
        q_is_nar   = (q == NAR_CODE);
        push_entry = {q_is_nar, q};
`else
        push_entry = q;
`endif
    end

    // Head read straight from the storage register. Outputs are forced to
    // zero whenever the FIFO is empty or held in reset.
    always_comb begin
        head     = mem[rd_ptr];
        out_data = out_valid ? head[WIDTH-1:0] : '0;
`ifdef POSIT_COLLECT_NAR_FLAG_EN
        out_nar  = out_valid & head[WIDTH];
`endif
    end

    // Storage array. It is not reset, because pointers and count decide
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (write) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Tracking state, pointers, occupancy and sticky flags. Reset discards
    // everything in flight and everything buffered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vsr      <= '0;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err      <= 1'b0;
`ifdef POSIT_COLLECT_NAR_FLAG_EN
            nar_seen <= 1'b0;
`endif
        end else begin
            vsr      <= vsr_next;
            inflight <= inflight_next;
            if (write) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (write && !pop) begin
                count <= count + W_CNT'(1);
            end else if (pop && !write) begin
                count <= count - W_CNT'(1);
            end
            if (overflow) begin
                err <= 1'b1;
            end
`ifdef POSIT_COLLECT_NAR_FLAG_EN
            if (push && q_is_nar) begin
                nar_seen <= 1'b1;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_posit_add_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_posit_add_collector
//  Purpose  : Self-checking bench for posit_add_collector. A 3-stage delay
//             line stands in for the adder. Each op carries its adder result
//             value, which comes out on q LATENCY cycles after the op is
//             presented. Accepted ops go onto a scoreboard queue, and the
//             FIFO output is compared against the front of that queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_posit_add_collector;

    localparam int WIDTH   = 7;
    localparam int LATENCY = 3;
    localparam int DEPTH   = 5;
    localparam int W_CNT   = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic             err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] out_data;
    logic [W_CNT-1:0] count;
    logic [W_CNT-1:0] inflight;
`ifdef POSIT_COLLECT_NAR_FLAG_EN
    logic             out_nar;
    logic             nar_seen;
`endif

    // Result value the stand-in adder will produce for the op currently
    // presented, plus its expected NaR flag.
    logic [WIDTH-1:0] op_res = '0;
    logic             op_nar = 1'b0;
    logic [WIDTH-1:0] pipe [LATENCY];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_acc  = 0;
    int n_out  = 0;
    logic [WIDTH:0] sb[$];
    int             out_times[$];

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             nar;
    } vec_t;
    vec_t tbl[$];

    posit_add_collector #(
        .WIDTH  (WIDTH),
        .LATENCY(LATENCY),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .q        (q),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .inflight (inflight),
`ifdef POSIT_COLLECT_NAR_FLAG_EN
        .out_nar  (out_nar),
        .nar_seen (nar_seen),
`endif
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in adder: a 3-register pipeline that shares rst with the DUT.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= op_res;
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign q = pipe[LATENCY-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge. The pop is handled
    // before the push so a fresh accept can never match an output in the
    // same cycle.
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (rst) begin
            if (out_valid && out_ready) begin
                out_times.push_back(cyc);
                n_out++;
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e[WIDTH-1:0]));
`ifdef POSIT_COLLECT_NAR_FLAG_EN
                    check("out_nar", 32'(out_nar), 32'(e[WIDTH]));
`endif
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back({op_nar, op_res});
                n_acc++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_outputs(input int target, input int bound, input string name);
        int i;
        i = 0;
        while (n_out < target && i < bound) begin
            tick(1);
            i++;
        end
        if (n_out < target) check({name, "_timeout"}, 32'(n_out), 32'(target));
    endtask

    task automatic single_op(input logic [WIDTH-1:0] res, input logic nar, input string name);
        int t0;
        int k;
        out_ready = 1'b1;
        op_res    = res;
        op_nar    = nar;
        in_valid  = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        t0 = cyc;
        tick(1);
        in_valid = 1'b0;
        k = 0;
        for (int i = 1; i <= 8 && k == 0; i++) begin
            @(negedge clk);
            if (out_valid) k = cyc - t0;
        end
        check({name, "_latency"}, 32'(k), 32'd4);
        @(negedge clk);
        check({name, "_count0"}, 32'(count), 32'd0);
        tick(1);
    endtask

    initial begin
        int t0;
        int n0;
        int drops;
        int acc;

        #200000;
        $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n0;
        int drops;
        int acc;

        // ---------------- reset ----------------
        rst = 1'b0;
        in_valid = 1'b1;
        tick(2);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        tick(1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_inflight", 32'(inflight), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready_after", 32'(in_ready), 32'd1);
        tick(1);

        // ---------------- single-op vectors ----------------
        tbl.push_back('{7'h28, 1'b0});   // 1.0 + 1.0 = 2.0
        tbl.push_back('{7'h7f, 1'b0});
        tbl.push_back('{7'h01, 1'b0});
        tbl.push_back('{7'h00, 1'b0});
`ifdef POSIT_COLLECT_NAR_FLAG_EN
        tbl.push_back('{7'h40, 1'b1});   // NaR + 1.0 = NaR
        tbl.push_back('{7'h28, 1'b0});
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            single_op(tbl[i].res, tbl[i].nar, $sformatf("vec%0d", i));
`ifdef POSIT_COLLECT_NAR_FLAG_EN
            if (i == 4) check("nar_seen_set", 32'(nar_seen), 32'd1);
            if (i == 5) check("nar_seen_sticky", 32'(nar_seen), 32'd1);
`endif
        end

        // ---------------- streaming: 20 back-to-back ----------------
        out_times.delete();
        n0 = n_out;
        drops = 0;
        t0 = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            op_res = 7'(i * 3 + 5);
            op_nar = 1'b0;
            @(negedge clk);
            if (!in_ready) drops++;
            if (i == 0) t0 = cyc;
            tick(1);
        end
        in_valid = 1'b0;
        wait_outputs(n0 + 20, 30, "stream");
        check("stream_in_ready_drops", 32'(drops), 32'd0);
        check("stream_outputs", 32'(n_out - n0), 32'd20);
        if (out_times.size() >= 20) begin
            check("stream_first_latency", 32'(out_times[0] - t0), 32'd4);
            check("stream_span", 32'(out_times[19] - out_times[0]), 32'd19);
        end else begin
            check("stream_times", 32'(out_times.size()), 32'd20);
        end
        tick(2);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            op_res = 7'(7'h50 + i);
            @(negedge clk);
            if (in_ready) acc++;
            tick(1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", 32'(acc), 32'd5);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_count", 32'(count), 32'd5);
        check("bp_inflight", 32'(inflight), 32'd0);
        check("bp_err", 32'(err), 32'd0);
        check("bp_out_data", 32'(out_data), 32'h50);
        tick(1);
        n0 = n_out;
        out_ready = 1'b1;
        wait_outputs(n0 + 5, 12, "bp_drain");
        @(negedge clk);
        check("bp_drain_count", 32'(count), 32'd0);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        tick(1);

        // ---------------- push and pop at the same edge near full ----------------
        out_ready = 1'b0;
        in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 12 && acc < 5; i++) begin
            op_res = 7'(7'h10 + i);
            @(negedge clk);
            if (in_ready) acc++;
            tick(1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && count != W_CNT'(DEPTH); i++) tick(1);
        check("pp_full", 32'(count), 32'd5);
        n0 = n_out;
        out_ready = 1'b1;                 // free one slot
        tick(1);
        out_ready = 1'b0;
        op_res = 7'h3c;
        in_valid = 1'b1;
        @(negedge clk);
        check("pp_credit", 32'(in_ready), 32'd1);
        tick(1);
        in_valid = 1'b0;
        tick(2);                          // now in the cycle the op reaches the FIFO
        out_ready = 1'b1;
        @(negedge clk);
        check("pp_pre_count", 32'(count), 32'd4);
        check("pp_pre_inflight", 32'(inflight), 32'd1);
        tick(1);
        out_ready = 1'b0;
        @(negedge clk);
        check("pp_count_kept", 32'(count), 32'd4);
        check("pp_inflight_0", 32'(inflight), 32'd0);
        tick(1);
        out_ready = 1'b1;
        wait_outputs(n0 + 6, 12, "pp_drain");
        @(negedge clk);
        check("pp_total", 32'(n_out - n0), 32'd6);
        check("pp_sb_empty", 32'(sb.size()), 32'd0);
        check("pp_err", 32'(err), 32'd0);
        tick(1);

        // ---------------- reset mid-flight ----------------
        out_ready = 1'b0;
        in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 12 && acc < 5; i++) begin
            op_res = 7'(7'h60 + i);
            @(negedge clk);
            if (in_ready) acc++;
            tick(1);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rmf_pre_count", 32'(count), 32'd2);
        check("rmf_pre_inflight", 32'(inflight), 32'd3);
        check("rmf_in_ready_low", 32'(in_ready), 32'd0);
        check("rmf_out_valid_low", 32'(out_valid), 32'd0);
        tick(1);
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        check("rmf_count", 32'(count), 32'd0);
        check("rmf_inflight", 32'(inflight), 32'd0);
        check("rmf_out_valid", 32'(out_valid), 32'd0);
        n0 = n_out;
        out_ready = 1'b1;
        tick(10);
        check("rmf_no_stale", 32'(n_out - n0), 32'd0);

        // ---------------- post-reset sanity ----------------
        single_op(7'h28, 1'b0, "post_rst");
        check("final_err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
